// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-return owner
// encoding and the starvation counter width.
package dmem_arbiter_pkg;

  typedef enum logic {
    ST_ARB       = 1'b0,
    ST_AUX_BURST = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_AUX  = 1'b1
  } owner_e;

  // Wide enough for MAX_WAIT up to 15.
  localparam int unsigned STARVE_W = 4;

  // Loads never drive a byte mask onto the macro.
  function automatic logic [3:0] access_mask(input logic we, input logic [3:0] mask);
    return we ? mask : 4'b0000;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (core priority, aux starvation guard and burst lock)
// in front of the single-port data memory with 1-cycle read latency.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [3:0]        core_mask_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  input  logic              aux_req_i,
  input  logic              aux_we_i,
  input  logic              aux_lock_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  input  logic [3:0]        aux_mask_i,
  input  logic [31:0]       aux_wdata_i,
  output logic              aux_gnt_o,
  output logic              aux_rvalid_o,
  output logic [31:0]       aux_rdata_o,
  output logic              mem_ceb_o,
  output logic              mem_web_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_mask_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_q_i
);

  localparam logic [STARVE_W-1:0] MAX_WAIT_C = STARVE_W'(MAX_WAIT);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                rd_pending_q, rd_pending_d;
  owner_e              rd_owner_q, rd_owner_d;
  logic                core_gnt, aux_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ARB;
      starve_q     <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= OWNER_CORE;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  always_comb begin
    core_gnt = 1'b0;
    aux_gnt  = 1'b0;
    state_d  = state_q;
    if (!reset) begin
      unique case (state_q)
        ST_ARB: begin
          aux_gnt  = aux_req_i && (!core_req_i || (starve_q == MAX_WAIT_C));
          core_gnt = core_req_i && !aux_gnt;
          if (aux_gnt && aux_lock_i) state_d = ST_AUX_BURST;
        end
        ST_AUX_BURST: begin
          aux_gnt = aux_req_i;
          if (!aux_req_i || !aux_lock_i) state_d = ST_ARB;
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!aux_req_i || aux_gnt) starve_d = '0;
    else if (starve_q != MAX_WAIT_C) starve_d = starve_q + 1'b1;
  end

  always_comb begin
    mem_ceb_o   = 1'b1;
    mem_web_o   = 1'b1;
    mem_addr_o  = '0;
    mem_mask_o  = '0;
    mem_wdata_o = '0;
    if (core_gnt) begin
      mem_ceb_o   = 1'b0;
      mem_web_o   = !core_we_i;
      mem_addr_o  = core_addr_i;
      mem_mask_o  = access_mask(core_we_i, core_mask_i);
      mem_wdata_o = core_wdata_i;
    end else if (aux_gnt) begin
      mem_ceb_o   = 1'b0;
      mem_web_o   = !aux_we_i;
      mem_addr_o  = aux_addr_i;
      mem_mask_o  = access_mask(aux_we_i, aux_mask_i);
      mem_wdata_o = aux_wdata_i;
    end
  end

  assign rd_pending_d = (core_gnt && !core_we_i) || (aux_gnt && !aux_we_i);
  assign rd_owner_d   = aux_gnt ? OWNER_AUX : OWNER_CORE;

  assign core_gnt_o = core_gnt;
  assign aux_gnt_o  = aux_gnt;

  // Return path is masked by reset so a load caught by reset never reports valid.
  assign core_rvalid_o = rd_pending_q && !reset && (rd_owner_q == OWNER_CORE);
  assign aux_rvalid_o  = rd_pending_q && !reset && (rd_owner_q == OWNER_AUX);
  assign core_rdata_o  = core_rvalid_o ? mem_q_i : '0;
  assign aux_rdata_o   = aux_rvalid_o  ? mem_q_i : '0;

endmodule
